vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Purpose: 640x480@60 raster timing generator with sync/blank decode, colour gating and animation tick.
// Latency: hsync/vsync/display_on lag counter_H/V by PIPE_DELAY pixel ticks; colour_out lags by PIPE_DELAY+1.
// Backpressure: none; the raster free-runs and colour_in is consumed on every pixel tick.
// Ports: clk, reset (synchronous, active-high); colour_in from the frame buffer controller;
//        counter_H/counter_V to the frame buffer controller; hsync/vsync (active low), display_on,
//        colour_out to the VGA pins; frame_tick and anim_phase to the sprite logic.
// Optional: define VGA_TEST_PATTERN_EN to add input test_pattern, which swaps colour_in for a
//        40x40 checkerboard aligned to the 16x12 tile grid.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int CLK_DIV     = 1,
  parameter int PIPE_DELAY  = 1,
  parameter int ANIM_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_pattern,
`endif
  input  logic       colour_in,
  output logic [9:0] counter_H,
  output logic [9:0] counter_V,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       colour_out,
  output logic       frame_tick,
  output logic       anim_phase
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int ANIM_W   = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  // Counters are 10 bits wide; anything that cannot be counted in them is rejected at elaboration.
  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_DELAY < 1 || PIPE_DELAY > 4 ||
        CLK_DIV < 1 || ANIM_FRAMES < 1) begin : g_bad_params
      $error("vga_timing_gen: illegal parameter combination");
    end
  endgenerate

  // Pixel-rate enable
  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;

  assign pix_en = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Raster counters
  logic h_last;
  logic v_last;

  assign h_last = (counter_H == 10'(H_TOTAL - 1));
  assign v_last = (counter_V == 10'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_H <= '0;
      counter_V <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        counter_H <= '0;
        counter_V <= v_last ? 10'd0 : counter_V + 10'd1;
      end else begin
        counter_H <= counter_H + 10'd1;
      end
    end
  end

  // Raw decode; compared as int so a sync end of exactly 1024 does not alias to 0.
  logic hs_raw;
  logic vs_raw;
  logic de_raw;

  assign hs_raw = !((int'(counter_H) >= HS_START) && (int'(counter_H) < HS_END));
  assign vs_raw = !((int'(counter_V) >= VS_START) && (int'(counter_V) < VS_END));
  assign de_raw = (int'(counter_H) < H_ACTIVE) && (int'(counter_V) < V_ACTIVE);

  // Delay line aligning sync/blank with the frame buffer read latency; bit 0 is the newest stage.
  logic [PIPE_DELAY-1:0] hs_pipe;
  logic [PIPE_DELAY-1:0] vs_pipe;
  logic [PIPE_DELAY-1:0] de_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      de_pipe <= '0;
    end else if (pix_en) begin
      hs_pipe <= PIPE_DELAY'({hs_pipe, hs_raw});
      vs_pipe <= PIPE_DELAY'({vs_pipe, vs_raw});
      de_pipe <= PIPE_DELAY'({de_pipe, de_raw});
    end
  end

  assign hsync      = hs_pipe[PIPE_DELAY-1];
  assign vsync      = vs_pipe[PIPE_DELAY-1];
  assign display_on = de_pipe[PIPE_DELAY-1];

  // Colour source
  logic colour_sel;

`ifdef VGA_TEST_PATTERN_EN
  logic [5:0]            px_in_tile;
  logic [3:0]            tile_col;
  logic [5:0]            line_in_tile;
  logic [3:0]            tile_row;
  logic [PIPE_DELAY-1:0] tp_pipe;
  logic                  tp_raw;

  // Tile counters shadow counter_H/V; tile_col simply wraps in the blanked region beyond column 15.
  assign tp_raw = tile_col[0] ^ tile_row[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      px_in_tile   <= '0;
      tile_col     <= '0;
      line_in_tile <= '0;
      tile_row     <= '0;
      tp_pipe      <= '0;
    end else if (pix_en) begin
      tp_pipe <= PIPE_DELAY'({tp_pipe, tp_raw});
      if (h_last) begin
        px_in_tile <= '0;
        tile_col   <= '0;
        if (v_last) begin
          line_in_tile <= '0;
          tile_row     <= '0;
        end else if (line_in_tile == 6'd39) begin
          line_in_tile <= '0;
          tile_row     <= (tile_row == 4'd11) ? 4'd0 : tile_row + 4'd1;
        end else begin
          line_in_tile <= line_in_tile + 6'd1;
        end
      end else if (px_in_tile == 6'd39) begin
        px_in_tile <= '0;
        tile_col   <= tile_col + 4'd1;
      end else begin
        px_in_tile <= px_in_tile + 6'd1;
      end
    end
  end

  assign colour_sel = test_pattern ? tp_pipe[PIPE_DELAY-1] : colour_in;
`else
  assign colour_sel = colour_in;
`endif

  // Colour gating, frame tick and animation phase
  logic [ANIM_W-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      colour_out <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      anim_phase <= 1'b0;
    end else begin
      frame_tick <= pix_en && h_last && v_last;
      if (pix_en) begin
        colour_out <= colour_sel & display_on;
      end
      if (frame_tick) begin
        if (frame_cnt == ANIM_W'(ANIM_FRAMES - 1)) begin
          frame_cnt  <= '0;
          anim_phase <= ~anim_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule
